// File: rtl/phase_ring_decoder.sv
// Receive-side 4-phase ring decoder: one-hot check, ring-order tracking, lock FSM, revolution count.
// Two edges from pin to output (input register + state register); free-running, no backpressure.
module phase_ring_decoder #(
  parameter int unsigned REV_W       = 8,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned UNLOCK_ERRS = 2
) (
  input  logic             Phase_Count,
  input  logic             invClear,
  input  logic             Phase0,
  input  logic             Phase1,
  input  logic             Phase2,
  input  logic             Phase3,
  output logic [1:0]       PhaseIdx,
  output logic             Locked,
  output logic             SeqErr,
  output logic             Fault,
  output logic             RevTick,
  output logic [REV_W-1:0] RevCount
);

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_s;
  logic [1:0]       r_last_idx;
  logic [3:0]       r_good_cnt;
  logic [3:0]       r_bad_cnt;
  logic             r_locked;
  logic             r_seq_err;
  logic             r_fault;
  logic             r_rev_tick;
  logic [REV_W-1:0] r_rev_cnt;

  logic       w_valid;
  logic [1:0] w_idx;
  logic       w_in_order;
  logic       w_wrap;
  logic [3:0] w_good_nxt;
  logic [3:0] w_bad_nxt;

  always_comb begin
    w_valid = 1'b1;
    w_idx   = 2'd0;
    case (r_s)
      4'b0001: w_idx = 2'd0;
      4'b0010: w_idx = 2'd1;
      4'b0100: w_idx = 2'd2;
      4'b1000: w_idx = 2'd3;
      default: w_valid = 1'b0;
    endcase
  end

  assign w_in_order = w_valid && (w_idx == r_last_idx + 2'd1);
  assign w_wrap     = (r_last_idx == 2'd3) && (w_idx == 2'd0);
  assign w_good_nxt = r_good_cnt + 4'd1;
  assign w_bad_nxt  = r_bad_cnt + 4'd1;

  always_ff @(posedge Phase_Count or negedge invClear) begin
    if (!invClear) begin
      r_state    <= HUNT;
      r_s        <= 4'b0000;
      r_last_idx <= 2'd0;
      r_good_cnt <= 4'd0;
      r_bad_cnt  <= 4'd0;
      r_locked   <= 1'b0;
      r_seq_err  <= 1'b0;
      r_fault    <= 1'b0;
      r_rev_tick <= 1'b0;
      r_rev_cnt  <= '0;
    end else begin
      r_s        <= {Phase3, Phase2, Phase1, Phase0};
      r_seq_err  <= 1'b0;
      r_rev_tick <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_valid) begin
            r_last_idx <= w_idx;
            r_good_cnt <= 4'd1;
            r_state    <= ACQ;
          end
        end
        ACQ: begin
          if (w_in_order) begin
            r_last_idx <= w_idx;
            r_good_cnt <= w_good_nxt;
            if (w_good_nxt == LOCK_C) begin
              r_state   <= LOCKED;
              r_locked  <= 1'b1;
              r_bad_cnt <= 4'd0;
            end
          end else if (w_valid) begin
            r_last_idx <= w_idx;
            r_good_cnt <= 4'd1;
          end else begin
            r_good_cnt <= 4'd0;
            r_state    <= HUNT;
          end
        end
        LOCKED: begin
          if (w_in_order) begin
            r_last_idx <= w_idx;
            r_bad_cnt  <= 4'd0;
            if (w_wrap) begin
              r_rev_tick <= 1'b1;
              r_rev_cnt  <= r_rev_cnt + REV_W'(1);
            end
          end else begin
            r_seq_err <= 1'b1;
            r_fault   <= 1'b1;
            // Out-of-order but valid samples resync the tracked index.
            if (w_valid) r_last_idx <= w_idx;
            if (w_bad_nxt == UNLOCK_C) begin
              r_state    <= HUNT;
              r_locked   <= 1'b0;
              r_good_cnt <= 4'd0;
              r_bad_cnt  <= 4'd0;
            end else begin
              r_bad_cnt <= w_bad_nxt;
            end
          end
        end
        default: begin
          r_state  <= HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign PhaseIdx = r_last_idx;
  assign Locked   = r_locked;
  assign SeqErr   = r_seq_err;
  assign Fault    = r_fault;
  assign RevTick  = r_rev_tick;
  assign RevCount = r_rev_cnt;

endmodule

// File: doc/phase_ring_decoder.md
# phase_ring_decoder

Receive-side companion of the 4-phase ring counter. Samples the four phase lines Phase0..Phase3 on the shared Phase_Count clock and decodes them into a 2-bit phase index. A HUNT/ACQ/LOCKED state machine checks that the lines are one-hot and that they advance in ring order. Downstream logic gets a lock indication, per-event error pulses, a sticky fault, and a revolution counter.

## Interface
Parameters:
- REV_W, 8, width of revolution counter RevCount
- LOCK_CNT, 4, consecutive valid in-order samples (including the first valid one) required to enter LOCKED; legal range 2..15
- UNLOCK_ERRS, 2, consecutive bad samples in LOCKED that force return to HUNT; legal range 1..15

Ports:
- Phase_Count  in  1  clock, rising-edge active
- invClear  in  1  reset, asynchronous, active-low
- Phase0  in  1  ring phase 0
- Phase1  in  1  ring phase 1
- Phase2  in  1  ring phase 2
- Phase3  in  1  ring phase 3
- PhaseIdx  out  2  last valid decoded index
- Locked  out  1  high while state is LOCKED
- SeqErr  out  1  one-cycle pulse per bad sample while LOCKED
- Fault  out  1  sticky; set by any SeqErr
- RevTick  out  1  one-cycle pulse on each in-order 3->0 step while LOCKED
- RevCount  out  REV_W  number of RevTick pulses, wraps modulo 2^REV_W

## Operation
- One clock (Phase_Count), asynchronous active-low reset (invClear).
- Input stage: register S captures {Phase3..Phase0} every rising edge. All decisions use S, never the raw pins.
- Valid sample: S is exactly one-hot. Index is 0..3 for Phase0..Phase3. 0000 and multi-hot samples are invalid.
- In-order: the sample is valid and idx == (last_idx + 1) mod 4. last_idx is held internally and driven on PhaseIdx.
- Internal counters: good_cnt (4 bits) and bad_cnt (4 bits).

State machine, per edge, evaluated on current S:
- HUNT (reset state):
  - valid -> last_idx=idx, good_cnt=1, go to ACQ.
  - invalid -> stay in HUNT.
- ACQ:
  - in-order -> last_idx=idx, good_cnt+1; if the new value == LOCK_CNT, go to LOCKED with bad_cnt=0.
  - valid but out-of-order -> last_idx=idx, good_cnt=1, stay in ACQ.
  - invalid -> good_cnt=0, go to HUNT; last_idx is held.
- LOCKED:
  - in-order -> last_idx=idx, bad_cnt=0.
  - in-order with last_idx==3 and idx==0 -> additionally pulse RevTick and increment RevCount.
  - out-of-order valid -> SeqErr pulse, last_idx=idx (resync), bad_cnt+1.
  - invalid -> SeqErr pulse, last_idx held, bad_cnt+1.
  - If the new bad_cnt == UNLOCK_ERRS, go to HUNT with good_cnt=0 and bad_cnt=0. The SeqErr pulse for that sample is still issued.
- Fault is set on the same edge as any SeqErr. Only reset clears it.
- RevCount persists across loss of lock and is cleared only by reset. It wraps from 2^REV_W-1 to 0 with no extra flag.
- RevTick and SeqErr never assert outside LOCKED. A 3->0 step processed in ACQ does not count, including the step that completes lock.

## Timing
- Reset (invClear low), applied immediately and asynchronously:
  - S=0000, state=HUNT, last_idx=0, good_cnt=0, bad_cnt=0.
  - PhaseIdx=0, Locked=0, SeqErr=0, Fault=0, RevTick=0, RevCount=0.
- After invClear rises, the first edge only samples S. No state change is possible before the second edge.
- Latency: a pin value set up before edge k is captured into S at edge k. Its effect on every output is visible after edge k+1, i.e. two edges from pin to output.
- Lock latency from a clean ring: the first valid sample is captured at edge 1, and Locked rises after edge 1+LOCK_CNT (edge 5 for default parameters).
- Loss of lock: the state after the edge processing the UNLOCK_ERRS-th consecutive bad sample is HUNT, and Locked is low immediately after that edge.
- Pulses: SeqErr and RevTick are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples give back-to-back high cycles.
- Locked, PhaseIdx, Fault and RevCount are registered outputs and change only on rising edges or on reset.

## Test plan
- Reset then ring 0,1,2,3,0,1 (one step per edge from edge 1) -> Locked=0 through edge 4, Locked=1 after edge 5; RevTick=1 only after edge 6, RevCount=1, PhaseIdx=0; SeqErr=0, Fault=0 throughout.
- While LOCKED, inject a single sample 0000 then resume the correct sequence -> one SeqErr pulse, Fault=1 and stays 1, Locked stays 1 (bad_cnt reset by the next in-order sample), PhaseIdx unchanged by the bad sample.
- While LOCKED, inject two consecutive multi-hot samples (0101) -> two SeqErr pulses; Locked falls after the edge processing the second one; the clean ring then relocks after 4 more valid in-order samples.
- In ACQ after 0,1, present 3 (skip) -> stay in ACQ, good_cnt restarts at 1, PhaseIdx=3; 0,1,2 follow and Locked rises on the 4th in-order sample (3,0,1,2); no RevTick for the 3->0 step in ACQ.
- With REV_W=2, run 5 full revolutions while LOCKED -> RevCount sequence 1,2,3,0,1 and 5 RevTick pulses.
- Assert invClear low mid-revolution between edges -> all outputs are at reset values before the next edge, including Fault=0 and RevCount=0; after release the lock sequence restarts from HUNT.
